// File: rtl/regfile_p.sv
// regfile_p: 2R1W register file with a pending-write scoreboard, same-cycle write
// forwarding and a one-register-per-cycle clear sweep after reset or flush.
module regfile_p #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            mark_en,
  input  logic [AW-1:0]   mark_addr,
  input  logic            clr_start,
  output logic            ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  state_t            state;
  logic [AW-1:0]     clr_ptr;
  logic [NREGS-1:1]  pending;
  logic [XLEN-1:0]   regs [NREGS];
  logic              wr_ok, mark_ok, hit1, hit2, ok1, ok2;
  function automatic logic ok(input logic [AW-1:0] a);
    return a != '0 && int'(a) < NREGS;
  endfunction
  assign wr_ok   = ready && wr_en && ok(wr_addr);
  assign mark_ok = ready && mark_en && ok(mark_addr);
  assign ok1     = ready && ok(rs1_addr);
  assign ok2     = ready && ok(rs2_addr);
  assign hit1    = BYPASS != 0 && wr_en && wr_addr == rs1_addr;
  assign hit2    = BYPASS != 0 && wr_en && wr_addr == rs2_addr;
  assign rs1_val  = !ok1 ? '0 : hit1 ? wr_data : regs[rs1_addr];
  assign rs2_val  = !ok2 ? '0 : hit2 ? wr_data : regs[rs2_addr];
  assign rs1_busy = ok1 && !hit1 && pending[rs1_addr];
  assign rs2_busy = ok2 && !hit2 && pending[rs2_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= AW'(1);
      pending <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + AW'(1);
      if (clr_ptr == LAST) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else if (clr_start) begin
      state   <= CLEAR;
      clr_ptr <= AW'(1);
      pending <= '0;
      ready   <= 1'b0;
    end else begin
      if (wr_ok) pending[wr_addr] <= 1'b0;
      // later assignment lets a mark override a same-register write
      if (mark_ok) pending[mark_addr] <= 1'b1;
    end
  // storage has no reset; contents are defined once the sweep has passed
  always_ff @(posedge clk)
    if (state == CLEAR) regs[clr_ptr] <= '0;
    else if (wr_ok) regs[wr_addr] <= wr_data;
endmodule

// File: tb/tb_regfile_p.sv
// tb_regfile_p: directed checks of regfile_p with default, no-bypass and 24-register instances.
module tb_regfile_p;
  logic clk = 0, rst_n = 0;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, wr_addr = 0, mark_addr = 0;
  logic [31:0] wr_data = 0;
  logic wr_en = 0, mark_en = 0, clr_start = 0;
  logic [31:0] v1_a, v2_a, v1_b, v2_b, v1_c, v2_c;
  logic b1_a, b2_a, b1_b, b2_b, b1_c, b2_c, rdy_a, rdy_b, rdy_c;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  regfile_p dut (.clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(v1_a), .rs2_val(v2_a), .rs1_busy(b1_a), .rs2_busy(b2_a), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .clr_start(clr_start), .ready(rdy_a));
  regfile_p #(.BYPASS(0)) dut0 (.clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(v1_b), .rs2_val(v2_b), .rs1_busy(b1_b), .rs2_busy(b2_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .clr_start(clr_start), .ready(rdy_b));
  regfile_p #(.NREGS(24)) dut24 (.clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(v1_c), .rs2_val(v2_c), .rs1_busy(b1_c), .rs2_busy(b2_c), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .clr_start(clr_start), .ready(rdy_c));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    int r32, r24;
    #2;
    total++; if ({rdy_a, rdy_b, rdy_c} !== 3'b0) $display("FAIL reset_ready got %b want 000", {rdy_a, rdy_b, rdy_c}); else passed++;
    total++; if ({v1_a, v2_a, b1_a, b2_a} !== '0) $display("FAIL reset_outputs got %h want 0", {v1_a, v2_a, b1_a, b2_a}); else passed++;
    #21 rst_n = 1;
    r32 = 0; r24 = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rdy_a && r32 == 0) r32 = i;
      if (rdy_c && r24 == 0) r24 = i;
    end
    total++; if (r32 !== 31) $display("FAIL ready_rise32 got %0d want 31", r32); else passed++;
    total++; if (r24 !== 23) $display("FAIL ready_rise24 got %0d want 23", r24); else passed++;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
      total++; if (v1_a !== 0 || v2_a !== 0) $display("FAIL init_zero x%0d got %h/%h want 0/0", i, v1_a, v2_a); else passed++;
    end
  endtask
  task automatic test_bypass;
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; #1;
    total++; if (v1_a !== 32'hDEADBEEF || b1_a !== 0) $display("FAIL bypass_same got %h/%b want deadbeef/0", v1_a, b1_a); else passed++;
    total++; if (v1_b !== 0) $display("FAIL nobypass_same got %h want 0", v1_b); else passed++;
    step(); wr_en = 0; #1;
    total++; if (v1_a !== 32'hDEADBEEF || v1_b !== 32'hDEADBEEF) $display("FAIL stored_x5 got %h/%h want deadbeef", v1_a, v1_b); else passed++;
  endtask
  task automatic test_x0;
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; mark_en = 1; mark_addr = 0; rs1_addr = 0; #1;
    total++; if (v1_a !== 0 || b1_a !== 0) $display("FAIL x0_same got %h/%b want 0/0", v1_a, b1_a); else passed++;
    step(); wr_en = 0; mark_en = 0; #1;
    total++; if (v1_a !== 0 || b1_a !== 0 || v1_b !== 0 || b1_b !== 0) $display("FAIL x0_after got %h/%b want 0/0", v1_a, b1_a); else passed++;
  endtask
  task automatic test_mark;
    mark_en = 1; mark_addr = 7; rs2_addr = 7; #1;
    total++; if (b2_a !== 0) $display("FAIL mark_same_cycle got %b want 0", b2_a); else passed++;
    step(); mark_en = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (b2_a !== 1 || b2_b !== 1) $display("FAIL mark_busy c%0d got %b/%b want 1/1", i, b2_a, b2_b); else passed++;
      if (i < 2) step();
    end
    step(); wr_en = 1; wr_addr = 7; wr_data = 32'hA5; #1;
    total++; if (b2_a !== 0 || v2_a !== 32'hA5) $display("FAIL write_busy_bypass got %b/%h want 0/a5", b2_a, v2_a); else passed++;
    total++; if (b2_b !== 1 || v2_b !== 0) $display("FAIL write_busy_nobypass got %b/%h want 1/0", b2_b, v2_b); else passed++;
    step(); wr_data = 32'h33; step(); #1;
    mark_en = 1; mark_addr = 7; wr_data = 32'hA5; step(); wr_en = 0; mark_en = 0; #1;
    total++; if (v2_a !== 32'hA5 || b2_a !== 1 || b2_b !== 1) $display("FAIL mark_wins got %h/%b/%b want a5/1/1", v2_a, b2_a, b2_b); else passed++;
    wr_en = 1; wr_addr = 8; wr_data = 32'h88; mark_en = 1; mark_addr = 9; step();
    wr_en = 1; wr_addr = 3; wr_data = 32'h55; mark_en = 0; step(); wr_en = 0;
    rs1_addr = 8; rs2_addr = 9; #1;
    total++; if (v1_a !== 32'h88 || b2_a !== 1 || b1_a !== 0) $display("FAIL diff_regs got %h/%b/%b want 88/1/0", v1_a, b2_a, b1_a); else passed++;
    rs1_addr = 3; #1;
    total++; if (v1_a !== 32'h55) $display("FAIL x3_written got %h want 55", v1_a); else passed++;
  endtask
  task automatic test_clear;
    int cnt;
    clr_start = 1; step(); clr_start = 0; #1;
    total++; if (rdy_a !== 0 || v1_a !== 0 || b2_a !== 0) $display("FAIL clear_enter got %b/%h/%b want 0/0/0", rdy_a, v1_a, b2_a); else passed++;
    cnt = 0;
    while (!rdy_a && cnt < 60) begin
      step(); cnt++;
      if (cnt == 4) begin wr_en = 1; wr_addr = 2; wr_data = 32'h77; mark_en = 1; mark_addr = 4; end
      if (cnt == 5) begin wr_en = 0; mark_en = 0; end
      clr_start = (cnt == 9);
    end
    clr_start = 0;
    total++; if (cnt !== 31) $display("FAIL clear_len got %0d want 31", cnt); else passed++;
    rs1_addr = 3; rs2_addr = 9; #1;
    total++; if (v1_a !== 0 || b2_a !== 0) $display("FAIL cleared_x3_x9 got %h/%b want 0/0", v1_a, b2_a); else passed++;
    rs1_addr = 2; rs2_addr = 4; #1;
    total++; if (v1_a !== 0 || b2_a !== 0) $display("FAIL dropped_in_clear got %h/%b want 0/0", v1_a, b2_a); else passed++;
  endtask
  task automatic test_nregs24;
    wr_en = 1; wr_addr = 30; wr_data = 32'hFF; mark_en = 1; mark_addr = 30; rs1_addr = 30; #1;
    total++; if (rdy_c !== 1 || v1_c !== 0 || b1_c !== 0) $display("FAIL oob_same got %b/%h/%b want 1/0/0", rdy_c, v1_c, b1_c); else passed++;
    step(); wr_en = 0; mark_en = 0; #1;
    total++; if (v1_c !== 0 || b1_c !== 0) $display("FAIL oob_after got %h/%b want 0/0", v1_c, b1_c); else passed++;
    total++; if (v1_a !== 32'hFF || b1_a !== 1) $display("FAIL x30_full got %h/%b want ff/1", v1_a, b1_a); else passed++;
    wr_en = 1; wr_addr = 23; wr_data = 32'h23; step(); wr_en = 0; rs2_addr = 23; #1;
    total++; if (v2_c !== 32'h23) $display("FAIL top_reg24 got %h want 23", v2_c); else passed++;
  endtask
  task automatic test_async_reset;
    rs1_addr = 30; #1;
    rst_n = 0; #1;
    total++; if (rdy_a !== 0 || v1_a !== 0 || b1_a !== 0) $display("FAIL async_reset got %b/%h/%b want 0/0/0", rdy_a, v1_a, b1_a); else passed++;
    step(); rst_n = 1;
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_mark();
    test_clear();
    test_nregs24();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
